// File: rtl/noc_fetch_ctrl.sv
// Per-port page-fetch sequencer: issues one NoC page request at a time, waits for the
// matching reply with a bounded timeout/retry loop, and returns data or an error.
module noc_fetch_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ID_W      = 6,
    parameter int MAX_WAIT  = 31,
    parameter int MAX_RETRY = 3,
    parameter int DROP_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [ID_W-1:0]      fetch_page,
    output logic                 fetch_ready,
    output logic [ID_W:0]        request,
    input  logic [DATA_W+ID_W:0] response,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [ID_W-1:0]      rsp_page,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic [1:0]           state_dbg
);

    localparam int WAIT_W  = (MAX_WAIT  < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshakes: fetch transfers when fetch_valid & fetch_ready on a rising edge;
    // a result transfers when rsp_valid & rsp_ready; rsp_* stay stable until then.

    logic [1:0]         state;
    logic [ID_W-1:0]    cur_page;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    logic               rsp_in_valid;
    logic [ID_W-1:0]    rsp_in_page;
    logic [DATA_W-1:0]  rsp_in_data;
    logic               in_flight;
    logic               match;
    logic               timeout;
    logic               drop;

    assign rsp_in_valid = response[0];
    assign rsp_in_page  = response[ID_W:1];
    assign rsp_in_data  = response[DATA_W+ID_W:ID_W+1];

    // Replies are matched on page id alone, so a late reply to an earlier attempt counts.
    assign in_flight = (state == S_ISSUE) || (state == S_WAIT);
    assign match     = in_flight && rsp_in_valid && (rsp_in_page == cur_page);
    assign timeout   = (state == S_WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign drop      = rsp_in_valid && !match;

    assign fetch_ready = (state == S_IDLE);
    assign rsp_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_page  <= '0;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            request   <= '0;
            rsp_data  <= '0;
            rsp_page  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_valid) begin
                        cur_page  <= fetch_page;
                        retry_cnt <= '0;
                        request   <= {1'b1, fetch_page};
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    request  <= '0;
                    wait_cnt <= '0;
                    if (match) begin
                        rsp_data <= rsp_in_data;
                        rsp_page <= cur_page;
                        rsp_err  <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A reply landing on the timeout cycle still wins.
                    if (match) begin
                        rsp_data <= rsp_in_data;
                        rsp_page <= cur_page;
                        rsp_err  <= 1'b0;
                        state    <= S_DONE;
                    end else if (timeout) begin
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            request   <= {1'b1, cur_page};
                            state     <= S_ISSUE;
                        end else begin
                            rsp_data <= '0;
                            rsp_page <= cur_page;
                            rsp_err  <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_noc_fetch_ctrl.sv
// Bench for noc_fetch_ctrl: directed and randomized fetches checked against a timing
// model that derives completion cycle, pulse count and result from the retry rules.
module tb_noc_fetch_ctrl;

    localparam int DATA_W    = 16;
    localparam int ID_W      = 6;
    localparam int DROP_W    = 8;
    localparam int PERIOD    = 33;  // one ISSUE cycle plus MAX_WAIT+1 WAIT cycles
    localparam int LAST_WAIT = 32;  // offset of the last WAIT cycle within an attempt
    localparam int ATTEMPTS  = 4;   // first try plus MAX_RETRY re-issues
    localparam int DROP_MAX  = 255;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 fetch_valid = 1'b0;
    logic [ID_W-1:0]      fetch_page = '0;
    logic                 fetch_ready;
    logic [ID_W:0]        request;
    logic [DATA_W+ID_W:0] response = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [DATA_W-1:0]    rsp_data;
    logic [ID_W-1:0]      rsp_page;
    logic                 rsp_err;
    logic                 busy;
    logic [DROP_W-1:0]    drop_cnt;
    logic [1:0]           state_dbg;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    // Expected results {err, page, data}, in fetch order.
    logic [DATA_W+ID_W:0] exp_q[$];

    noc_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_page  (fetch_page),
        .fetch_ready (fetch_ready),
        .request     (request),
        .response    (response),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_page    (rsp_page),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bump(input int v);
        return (v < DROP_MAX) ? v + 1 : DROP_MAX;
    endfunction

    // r: attempt index whose window carries the reply (>= ATTEMPTS means no reply),
    // o: offset of the reply inside that attempt (0 = ISSUE cycle).
    task automatic run_fetch(input logic [ID_W-1:0] p, input int r, input int o,
                             input logic [DATA_W-1:0] d, input bit noise, input int noise_off,
                             input logic [ID_W-1:0] noise_id, input int hold, input bit done_noise);
        int c;
        int pulses;
        int exp_pulses;
        bit noise_eff;
        logic [DATA_W+ID_W:0] exp_res;

        if (r >= ATTEMPTS) begin
            c          = PERIOD * (ATTEMPTS - 1) + LAST_WAIT;
            exp_pulses = ATTEMPTS;
            exp_q.push_back({1'b1, p, {DATA_W{1'b0}}});
        end else begin
            c          = PERIOD * r + o;
            exp_pulses = r + 1;
            exp_q.push_back({1'b0, p, d});
        end
        noise_eff = noise && (noise_off <= c) && !(r < ATTEMPTS && noise_off == c);
        if (noise_eff) exp_drop = bump(exp_drop);

        @(posedge clk); #1;
        fetch_valid = 1'b1;
        fetch_page  = p;
        @(negedge clk);
        check("fetch_ready_idle", fetch_ready, 1);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        fetch_page  = ID_W'($urandom);

        pulses = 0;
        for (int off = 0; off <= c; off++) begin
            response = '0;
            if (r < ATTEMPTS && off == c)
                response = {d, p, 1'b1};
            else if (noise_eff && off == noise_off)
                response = {16'hBEEF, noise_id, 1'b1};
            @(negedge clk);
            if (request[ID_W]) begin
                check("req_value", request, {1'b1, p});
                check("req_offset", off, PERIOD * pulses);
                pulses++;
            end
            if (off == c) check("not_done_early", rsp_valid, 0);
            @(posedge clk); #1;
        end

        response = '0;
        @(negedge clk);
        exp_res = exp_q.pop_front();
        check("pulse_count", pulses, exp_pulses);
        check("req_idle", request, 0);
        check("done_valid", rsp_valid, 1);
        check("done_busy", busy, 1);
        check("rsp_data", rsp_data, exp_res[DATA_W-1:0]);
        check("rsp_page", rsp_page, exp_res[DATA_W+ID_W-1:DATA_W]);
        check("rsp_err", rsp_err, exp_res[DATA_W+ID_W]);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            response = done_noise ? {DATA_W'($urandom), ID_W'($urandom), 1'b1} : '0;
            if (done_noise) exp_drop = bump(exp_drop);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_fetch_ready", fetch_ready, 0);
            check("hold_data", rsp_data, exp_res[DATA_W-1:0]);
            check("hold_err", rsp_err, exp_res[DATA_W+ID_W]);
        end

        @(posedge clk); #1;
        response  = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_valid", rsp_valid, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", rsp_valid, 0);
        check("post_fetch_ready", fetch_ready, 1);
        check("post_busy", busy, 0);
        check("drop_cnt", drop_cnt, exp_drop);
    endtask

    initial begin
        int r;
        int o;
        int c;
        logic [ID_W-1:0] p;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_ready", fetch_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_request", request, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_page", rsp_page, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;

        // Single reply three cycles after the request pulse.
        run_fetch(6'd5, 0, 3, 16'h1234, 0, 0, 6'd0, 0, 0);
        // No reply at all: four pulses, then an error.
        run_fetch(6'd9, ATTEMPTS, 0, 16'h0, 0, 0, 6'd0, 0, 0);
        // Wrong-id reply during WAIT is dropped, correct one arrives later.
        run_fetch(6'd9, 0, 20, 16'h0042, 1, 5, 6'd10, 0, 0);
        // Reply on the timeout cycle of the first attempt.
        run_fetch(6'd17, 0, LAST_WAIT, 16'hA5C3, 0, 0, 6'd0, 0, 0);
        // Page 0 replied during the second ISSUE cycle; page 63 on the very last WAIT cycle.
        run_fetch(6'd0, 1, 0, 16'hFFFF, 0, 0, 6'd0, 0, 0);
        run_fetch(6'd63, ATTEMPTS - 1, LAST_WAIT, 16'h0001, 0, 0, 6'd0, 0, 0);

        // Reset during WAIT aborts the fetch; the stale reply is then dropped.
        @(posedge clk); #1;
        fetch_valid = 1'b1;
        fetch_page  = 6'd3;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_drop = 0;
        #2;
        check("abort_busy", busy, 0);
        check("abort_request", request, 0);
        check("abort_drop", drop_cnt, 0);
        @(posedge clk); #1;
        reset    = 1'b0;
        response = {16'h0007, 6'd3, 1'b1};
        exp_drop = bump(exp_drop);
        @(negedge clk);
        check("stale_busy", busy, 0);
        check("stale_valid", rsp_valid, 0);
        @(posedge clk); #1;
        response = '0;
        @(negedge clk);
        check("stale_drop", drop_cnt, exp_drop);
        check("stale_valid_after", rsp_valid, 0);
        run_fetch(6'd4, 0, 7, 16'hC0DE, 0, 0, 6'd0, 0, 0);

        // Ten cycles held in DONE with a valid response every cycle.
        run_fetch(6'd21, 0, 2, 16'h7777, 0, 0, 6'd0, 10, 1);

        for (int i = 0; i < 16; i++) begin
            p = ID_W'($urandom_range(0, 63));
            r = $urandom_range(0, ATTEMPTS);
            o = $urandom_range(0, LAST_WAIT);
            c = (r >= ATTEMPTS) ? PERIOD * (ATTEMPTS - 1) + LAST_WAIT : PERIOD * r + o;
            run_fetch(p, r, o, DATA_W'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, c), p ^ ID_W'($urandom_range(1, 63)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_fetch_ctrl.md
Name: noc_fetch_ctrl

Overview:
Per-port page-fetch sequencer between one pagerank compute unit and one requester/responder port pair of the 4-port NoC. It accepts one page-value fetch at a time from the compute unit and issues the request onto the NoC request port. It then waits for the matching response, applies a MAX_WAIT timeout with bounded retries, and hands the reply (or an error) back to the compute unit. One instance is placed per NoC port (4 total).

Parameters:
DATA_W, 16, width of page value carried in a response
ID_W, 6, page id width
MAX_WAIT, 31, WAIT-state cycles before timeout (5-bit counter)
MAX_RETRY, 3, re-issues allowed after first attempt
DROP_W, 8, width of dropped-response counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
fetch_valid  input  1  compute unit presents a fetch
fetch_page  input  ID_W  page id to fetch
fetch_ready  output  1  block can accept a fetch (high only in IDLE)
request  output  ID_W+1  to NoC requester: {valid, page id}; 0 when idle
response  input  DATA_W+ID_W+1  from NoC: {data, page id, valid}; valid = bit 0
rsp_valid  output  1  result available (high only in DONE)
rsp_ready  input  1  compute unit consumes result
rsp_data  output  DATA_W  fetched page value; 0 on error
rsp_page  output  ID_W  page id of the result
rsp_err  output  1  retries exhausted, no reply
busy  output  1  state != IDLE
drop_cnt  output  DROP_W  saturating count of discarded responses

Behaviour:
- Reset (async, any state): state=IDLE; request=0; rsp_data=0; rsp_page=0; rsp_err=0; drop_cnt=0; wait_cnt=0; retry_cnt=0. Combinational outputs: fetch_ready=1, rsp_valid=0, busy=0.
- request, rsp_data, rsp_page, rsp_err and drop_cnt are registered. fetch_ready, rsp_valid and busy decode the state.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: when fetch_valid & fetch_ready, latch fetch_page into cur_page, set retry_cnt=0 and go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): request={1,cur_page} for exactly this cycle (registered, so it is visible the cycle after the accept/timeout edge). Clear wait_cnt and go to WAIT. Request returns to 0 the next cycle.
- WAIT: wait_cnt increments each cycle.
  - Match = response[0]=1 and response[ID_W:1]==cur_page. A match is accepted in ISSUE or WAIT: capture rsp_data=response[DATA_W+ID_W:ID_W+1], rsp_page=cur_page, rsp_err=0, then go to DONE.
  - Timeout = wait_cnt==MAX_WAIT with no match, so WAIT lasts MAX_WAIT+1 cycles.
  - On timeout, if retry_cnt<MAX_RETRY: retry_cnt++ and go to ISSUE. Otherwise: rsp_data=0, rsp_page=cur_page, rsp_err=1, go to DONE.
  - A match and a timeout in the same cycle: the match wins.
- DONE: rsp_valid=1. Outputs are held stable until rsp_ready. When rsp_ready is high, go to IDLE; fetch_ready returns high the next cycle, so there are no back-to-back accepts.
- Dropped responses: any response[0]=1 that is not an accepted match (wrong id in ISSUE/WAIT, or any valid response in IDLE/DONE). drop_cnt++ per cycle, saturating at 2^DROP_W-1.
- A late reply to an earlier attempt of the same page is a legal match.
- Page id 0 and 63 are legal, with no special cases.
- Reset mid-operation aborts the fetch. A reply arriving afterwards is dropped and counted.
- Total request pulses per fetch ≤ MAX_RETRY+1.

Test Plan:
1. Reset, then fetch_page=5 with a response {0x1234,5,1} 3 cycles after the request pulse → one request=7'h45 pulse; rsp_valid with rsp_data=0x1234, rsp_page=5, rsp_err=0.
2. Fetch page 9 with no response → exactly 4 request pulses spaced 33 cycles apart (ISSUE+32 WAIT); then rsp_valid, rsp_err=1, rsp_data=0, rsp_page=9.
3. Fetch page 9 with only a wrong-id response {0xBEEF,10,1} during WAIT → reply ignored, drop_cnt=1, WAIT continues; a later {0x0042,9,1} yields rsp_data=0x0042.
4. Matching response arriving in the same cycle as wait_cnt==31 on the first attempt → no reissue, rsp_err=0, data captured.
5. Hold rsp_ready=0 for 10 cycles in DONE while driving a valid response each cycle → rsp_* stable, fetch_ready=0, drop_cnt=10; rsp_ready=1 → IDLE next cycle.
6. Assert reset during WAIT of page 3, release, then inject {0x7,3,1} → busy=0, no rsp_valid, drop_cnt=1; a new fetch of page 4 proceeds normally.
